// File: rtl/pcie_tx_arb.sv
// Two-requester arbiter for the ECP3 PCIe VC0 transmit port: requester 0 = completions, requester 1 = posted DMA writes.
// Build with PCIE_TX_ARB_RR_EN defined for round-robin arbitration; otherwise fixed priority per CPL_FIRST.
module pcie_tx_arb #(
    parameter bit          CPL_FIRST  = 1'b1,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic        pcie_clk,
    input  logic        rstn,
    input  logic        r0_req,
    input  logic        r0_st,
    input  logic        r0_end,
    input  logic [15:0] r0_data,
    input  logic        r1_req,
    input  logic        r1_st,
    input  logic        r1_end,
    input  logic [15:0] r1_data,
    input  logic [9:0]  r1_len,
    output logic        r0_gnt,
    output logic        r1_gnt,
    output logic        r0_rdy,
    output logic        r1_rdy,
    output logic        tx_req,
    output logic        tx_st,
    output logic        tx_end,
    output logic [15:0] tx_data,
    input  logic        tx_rdy,
    input  logic [8:0]  tx_ca_ph,
    input  logic [12:0] tx_ca_pd,
    input  logic        tx_ca_p_recheck,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

    localparam logic [1:0] GAP_LAST = 2'(GAP_CYCLES - 1);

    state_t      state, state_nxt;
    logic        sel, sel_nxt;
    logic [1:0]  gap_cnt;
    logic [10:0] r1_dw, pd_need;
    logic        ph_ok, pd_ok, credit_ok;
    logic        elig0, elig1, pick, xfer;

    // Credits are evaluated live every IDLE cycle, so the recheck pulse carries no extra information.
    logic unused_recheck;
    assign unused_recheck = tx_ca_p_recheck;

    assign r1_dw     = (r1_len == 10'd0) ? 11'd1024 : {1'b0, r1_len};
    assign pd_need   = (r1_dw + 11'd3) >> 2;
    assign ph_ok     = tx_ca_ph[8] | (tx_ca_ph[7:0] != 8'd0);
    assign pd_ok     = tx_ca_pd[12] | ({1'b0, pd_need} <= tx_ca_pd[11:0]);
    assign credit_ok = ph_ok & pd_ok;
    assign elig0     = r0_req;
    assign elig1     = r1_req & credit_ok;

`ifdef PCIE_TX_ARB_RR_EN
    // ptr names the requester that wins the next tie; it flips to the other side on every grant drop.
    logic ptr;
    always_ff @(posedge pcie_clk or negedge rstn) begin
        if (!rstn)
            ptr <= 1'b0;
        else if (state == XFER && state_nxt != XFER)
            ptr <= ~sel;
    end
    assign pick = (elig0 && elig1) ? ptr : elig1;
`else
    assign pick = (elig0 && elig1) ? ~CPL_FIRST : elig1;
`endif

    always_ff @(posedge pcie_clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            sel     <= 1'b0;
            gap_cnt <= 2'd0;
        end else begin
            state   <= state_nxt;
            sel     <= sel_nxt;
            gap_cnt <= (state == GAP) ? gap_cnt + 2'd1 : 2'd0;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        case (state)
            IDLE: if (elig0 || elig1) begin
                state_nxt = REQ;
                sel_nxt   = pick;
            end
            // Requester dropping req here is a protocol error; the packet is still taken on tx_rdy.
            REQ:  if (tx_rdy) state_nxt = XFER;
            XFER: if (tx_end && tx_rdy) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
            GAP:  if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // All outputs decode from registered state so async reset clears them immediately.
    assign xfer    = (state == XFER);
    assign tx_req  = (state == REQ);
    assign busy    = (state != IDLE);
    assign r0_gnt  = xfer & ~sel;
    assign r1_gnt  = xfer & sel;
    assign r0_rdy  = r0_gnt & tx_rdy;
    assign r1_rdy  = r1_gnt & tx_rdy;
    assign tx_st   = xfer & (sel ? r1_st  : r0_st);
    assign tx_end  = xfer & (sel ? r1_end : r0_end);
    assign tx_data = xfer ? (sel ? r1_data : r0_data) : 16'h0000;

endmodule

// File: tb/tb_pcie_tx_arb.sv
// Directed bench for pcie_tx_arb: expected TLP words are queued when a packet is offered and popped as the core accepts them.
module tb_pcie_tx_arb;

    localparam int GAP = 1;

    logic        pcie_clk, rstn;
    logic        r0_req, r0_st, r0_end, r1_req, r1_st, r1_end;
    logic [15:0] r0_data, r1_data;
    logic [9:0]  r1_len;
    logic        r0_gnt, r1_gnt, r0_rdy, r1_rdy;
    logic        tx_req, tx_st, tx_end, tx_rdy, tx_ca_p_recheck, busy;
    logic [15:0] tx_data;
    logic [8:0]  tx_ca_ph;
    logic [12:0] tx_ca_pd;

    int errs   = 0;
    int checks = 0;
    logic [15:0] sb_q[$];

    pcie_tx_arb #(.CPL_FIRST(1'b1), .GAP_CYCLES(GAP)) dut (
        .pcie_clk(pcie_clk), .rstn(rstn),
        .r0_req(r0_req), .r0_st(r0_st), .r0_end(r0_end), .r0_data(r0_data),
        .r1_req(r1_req), .r1_st(r1_st), .r1_end(r1_end), .r1_data(r1_data),
        .r1_len(r1_len), .r0_gnt(r0_gnt), .r1_gnt(r1_gnt),
        .r0_rdy(r0_rdy), .r1_rdy(r1_rdy),
        .tx_req(tx_req), .tx_st(tx_st), .tx_end(tx_end), .tx_data(tx_data),
        .tx_rdy(tx_rdy), .tx_ca_ph(tx_ca_ph), .tx_ca_pd(tx_ca_pd),
        .tx_ca_p_recheck(tx_ca_p_recheck), .busy(busy)
    );

    initial pcie_clk = 1'b0;
    always #4 pcie_clk = ~pcie_clk;

    // The bench never withdraws a request while the core request is pending.
    always @(posedge pcie_clk)
        if (rstn && tx_req)
            assert (r0_req || r1_req) else begin
                errs++;
                $error("FAIL req_dropped_in_req: got 0 want 1");
            end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pcie_clk);
        #1;
    endtask

    // Winner drives its framing; the loser drives a poison word so a wrong mux select shows up.
    task automatic drive_r(input int w, input logic st, input logic en, input logic [15:0] d);
        if (w == 0) begin
            r0_st = st; r0_end = en; r0_data = d;
            r1_st = 1'b0; r1_end = 1'b1; r1_data = 16'hDEAD;
        end else begin
            r1_st = st; r1_end = en; r1_data = d;
            r0_st = 1'b0; r0_end = 1'b1; r0_data = 16'hDEAD;
        end
    endtask

    // Requester w's req must already be high. lat: expected cycles until tx_req (-1 skips).
    task automatic run_pkt(input int w, input int nw, input logic [15:0] base,
                           input int rdy_dly, input int stall_at, input bit drop, input int lat);
        int n, req_cyc, idx, stall, cyc;
        for (int i = 0; i < nw; i++) sb_q.push_back(base + 16'(i));
        drive_r(w, 1'b0, 1'b0, 16'h0000);
        n = 0;
        while (!tx_req && n < 10) begin step(); n++; end
        chk("tx_req_seen", tx_req, 1);
        if (lat >= 0) chk("tx_req_latency", n, lat);
        req_cyc = 0;
        for (int i = 0; i < rdy_dly; i++) begin req_cyc += int'(tx_req); step(); end
        tx_rdy = 1'b1;
        #1;
        req_cyc += int'(tx_req);
        step();
        chk("tx_req_cycles", req_cyc, rdy_dly + 1);
        chk("tx_req_low_in_xfer", tx_req, 0);
        chk("gnt_winner", (w == 0) ? r0_gnt : r1_gnt, 1);
        chk("gnt_loser", (w == 0) ? r1_gnt : r0_gnt, 0);
        idx = 0; stall = 0; cyc = 0;
        while (idx < nw && cyc < 64) begin
            drive_r(w, idx == 0, idx == nw - 1, base + 16'(idx));
            if (idx == stall_at && stall < 2) begin tx_rdy = 1'b0; stall++; end
            else tx_rdy = 1'b1;
            #1;
            chk("req_rdy_follows", (w == 0) ? r0_rdy : r1_rdy, tx_rdy);
            if (tx_rdy) begin
                chk("tx_data", tx_data, sb_q.pop_front());
                chk("tx_st", tx_st, idx == 0);
                chk("tx_end", tx_end, idx == nw - 1);
                if (idx == nw - 1 && drop) begin
                    if (w == 0) r0_req = 1'b0; else r1_req = 1'b0;
                end
                idx++;
            end else begin
                chk("tx_data_held", tx_data, base + 16'(idx));
            end
            step();
            cyc++;
        end
        chk("pkt_complete", idx, nw);
        tx_rdy = 1'b0;
        drive_r(w, 1'b0, 1'b0, 16'h0000);
        #1;
        chk("gnt_drop", r0_gnt | r1_gnt, 0);
        chk("tx_end_idle", tx_end, 0);
        chk("busy_in_gap", busy, GAP > 0);
        for (int i = 0; i < GAP; i++) step();
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        rstn = 1'b0; tx_rdy = 1'b0; tx_ca_p_recheck = 1'b0;
        r0_req = 1'b0; r1_req = 1'b0; r1_len = 10'd16;
        tx_ca_ph = 9'd1; tx_ca_pd = 13'd0;
        drive_r(0, 1'b0, 1'b0, 16'h0000);
        #1;
        chk("rst_tx_req", tx_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", {r0_gnt, r1_gnt}, 0);
        chk("rst_tx_data", tx_data, 0);
        step(); step();
        rstn = 1'b1;
        step();

        // Single 6-word completion, tx_rdy 3 cycles after tx_req.
        r0_req = 1'b1;
        run_pkt(0, 6, 16'h0A00, 3, -1, 1'b1, 1);

        // Throttled completion: tx_rdy low two cycles on word 2.
        r0_req = 1'b1;
        run_pkt(0, 5, 16'h0B00, 0, 2, 1'b1, 1);

        // Posted write held off by data credits, released by more credits.
        r1_len = 10'd16; tx_ca_pd = 13'd3; r1_req = 1'b1;
        step(); step();
        chk("credit_blocked_a", tx_req, 0);
        step(); step();
        chk("credit_blocked_b", tx_req, 0);
        tx_ca_pd = 13'd4; tx_ca_p_recheck = 1'b1;
        step();
        tx_ca_p_recheck = 1'b0;
        step();
        chk("credit_release", tx_req, 1);
        run_pkt(1, 4, 16'h1000, 0, -1, 1'b1, 0);

        // Infinite data credit.
        tx_ca_pd = 13'h1000; r1_req = 1'b1;
        run_pkt(1, 3, 16'h1100, 1, -1, 1'b1, 1);

        // len=0 means 1024 DW, i.e. 256 credits.
        r1_len = 10'd0; tx_ca_pd = 13'd255; r1_req = 1'b1;
        step(); step(); step();
        chk("len0_blocked", tx_req, 0);
        tx_ca_pd = 13'd256;
        run_pkt(1, 3, 16'h1200, 0, -1, 1'b1, 1);

        // Four rounds of simultaneous requests.
        r1_len = 10'd4; tx_ca_pd = 13'h1000;
        r0_req = 1'b1; r1_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef PCIE_TX_ARB_RR_EN
            run_pkt(k % 2, 3, 16'h2000 + 16'(k * 16), 0, -1, 1'b0, 1);
`else
            run_pkt(0, 3, 16'h2000 + 16'(k * 16), 0, -1, 1'b0, 1);
`endif
        end
        r0_req = 1'b0; r1_req = 1'b0;
        step();
        chk("rounds_quiet", tx_req, 0);

        // Reset mid-packet clears everything without a clock edge.
        r0_req = 1'b1;
        step(); step();
        chk("pre_rst_tx_req", tx_req, 1);
        tx_rdy = 1'b1;
        step();
        drive_r(0, 1'b1, 1'b0, 16'h3000);
        #1;
        chk("pre_rst_gnt", r0_gnt, 1);
        chk("pre_rst_tx_st", tx_st, 1);
        rstn = 1'b0;
        #1;
        chk("async_rst_st", tx_st, 0);
        chk("async_rst_end_req", {tx_end, tx_req}, 0);
        chk("async_rst_gnt", {r0_gnt, r1_gnt}, 0);
        chk("async_rst_data", tx_data, 0);
        tx_rdy = 1'b0;
        drive_r(0, 1'b0, 1'b0, 16'h0000);
        step();
        rstn = 1'b1;
        step();
        run_pkt(0, 4, 16'h3100, 2, -1, 1'b1, -1);

        chk("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
